// File: rtl/flip_flop_if.sv
// Data/enable/output bundle for the load-enable register.
// The producer drives d and en, and the register returns q.
interface flip_flop_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] d;
  logic             en;
  logic [WIDTH-1:0] q;

  modport master (
    output d,
    output en,
    input  q
  );

  modport slave (
    input  d,
    input  en,
    output q
  );
endinterface

// File: rtl/flip_flop.sv
// Load-enable register bank with synchronous active-low reset to RESET_VAL.
// q is purely registered, so there is no combinational path from any input to q.
module flip_flop #(
  parameter int             WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic        clk,
  input logic        rset,
  flip_flop_if.slave bus
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (bus.en) begin
      q_d = bus.d;
    end
  end

  // Reset has priority, so the d value on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q = q_q;

  en_known_a : assert property (@(posedge clk) rset |-> !$isunknown(bus.en))
    else $error("flip_flop: en unknown while out of reset");

endmodule

// File: tb/tb_flip_flop.sv
// Directed bench for flip_flop with a 32-bit default instance and an 8-bit instance whose RESET_VAL is 8'h3C.
// Both instances share clk, rset and en. The 8-bit instance sees the low byte of d.
module tb_flip_flop;

  logic clk;
  logic rset;
  int   total;
  int   bad;

  flip_flop_if #(.WIDTH(32)) bus32 ();
  flip_flop_if #(.WIDTH(8))  bus8  ();

  flip_flop #(.WIDTH(32)) u_ff32 (
    .clk  (clk),
    .rset (rset),
    .bus  (bus32.slave)
  );

  flip_flop #(.WIDTH(8), .RESET_VAL(8'h3C)) u_ff8 (
    .clk  (clk),
    .rset (rset),
    .bus  (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [31:0] dv);
    rset     = r;
    bus32.en = e;
    bus8.en  = e;
    bus32.d  = dv;
    bus8.d   = dv[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string tag, input logic [31:0] e32, input logic [7:0] e8);
    chk({tag, "_w32"}, bus32.q, e32);
    chk({tag, "_w8"}, {24'h0, bus8.q}, {24'h0, e8});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b0, 32'h0);
    @(negedge clk);

    // First load out of power-up.
    drive(1'b1, 1'b1, 32'h0000_000E);
    tick();
    chk2("load_e", 32'h0000_000E, 8'h0E);

    // Reset takes priority over a pending load and holds while asserted.
    drive(1'b0, 1'b1, 32'h0000_000D);
    tick();
    chk2("rst_beats_load", 32'h0, 8'h3C);
    drive(1'b0, 1'b1, 32'd8);
    tick();
    chk2("rst_held1", 32'h0, 8'h3C);
    tick();
    chk2("rst_held2", 32'h0, 8'h3C);

    // Hold after reset release with en low.
    drive(1'b1, 1'b0, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk2($sformatf("hold_after_rst%0d", i), 32'h0, 8'h3C);
    end

    // Load, then hold with new d.
    drive(1'b1, 1'b1, 32'd8);
    tick();
    chk2("load_8", 32'd8, 8'h08);
    drive(1'b1, 1'b0, 32'h1234_5678);
    tick();
    chk2("hold_8a", 32'd8, 8'h08);
    tick();
    chk2("hold_8b", 32'd8, 8'h08);

    // Back-to-back loads.
    drive(1'b1, 1'b1, 32'hA5A5_A5A5);
    tick();
    chk2("b2b_a5", 32'hA5A5_A5A5, 8'hA5);
    drive(1'b1, 1'b1, 32'h5A5A_5A5A);
    tick();
    chk2("b2b_5a", 32'h5A5A_5A5A, 8'h5A);

    // d and en changing between edges do not reach q until the next edge.
    drive(1'b1, 1'b1, 32'h1122_3344);
    #3;
    chk2("mid_no_change", 32'h5A5A_5A5A, 8'h5A);
    drive(1'b1, 1'b0, 32'hCAFE_F00D);
    #2;
    chk2("mid_no_change2", 32'h5A5A_5A5A, 8'h5A);
    drive(1'b1, 1'b1, 32'hCAFE_F00D);
    tick();
    chk2("mid_last_wins", 32'hCAFE_F00D, 8'h0D);

    // Reset in mid-operation, then release with en low.
    drive(1'b0, 1'b1, 32'h9999_9999);
    tick();
    chk2("rst_mid", 32'h0, 8'h3C);
    drive(1'b1, 1'b0, 32'h7777_7777);
    tick();
    chk2("release_hold", 32'h0, 8'h3C);
    drive(1'b1, 1'b1, 32'h0000_00C3);
    tick();
    chk2("load_after_release", 32'h0000_00C3, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
